// File: rtl/keypad_scan.sv
// Matrix keypad scanner: drives one column low at a time, debounces the
// synchronized row inputs and reports the accepted key as a code plus a
// one-cycle key_valid pulse. key_down stays high until a debounced release.
//
// Output handshake: key_valid is a single-cycle strobe with no back-pressure
// (there is no ready). key_code and multi_key are valid in the cycle key_valid
// is high and hold their value until the next accepted key or reset.
module keypad_scan #(
  parameter int NUM_COLS     = 4,
  parameter int NUM_ROWS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  localparam int CODE_W      = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] kpr,
  output logic [NUM_COLS-1:0] kpc,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                multi_key
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [NUM_COLS-1:0] KPC_COL0 = {1'b0, {(NUM_COLS-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [NUM_ROWS-1:0] kpr_m, kpr_s;
  logic [DIV_W-1:0]    div;
  logic                tick;
  logic [COL_W-1:0]    col, col_n, col_inc;
  logic [3:0]          stab_cnt, stab_n;
  logic [NUM_ROWS-1:0] cap, cap_n;
  logic                accept, release_done;
  logic                all_ones;
  logic [NUM_COLS-1:0] kpc_n;
  logic [CODE_W-1:0]   code_n;
  logic                multi_n;
  int                  row_sel;
  int                  zero_cnt;

  assign tick     = (div == DIV_W'(SCAN_DIV - 1));
  assign all_ones = &kpr_s;
  assign col_inc  = (col == COL_W'(NUM_COLS - 1)) ? '0 : col + COL_W'(1);

  // Two-flop synchronizer for the asynchronous row inputs (idle = all ones).
  always_ff @(posedge clk) begin
    if (reset) begin
      kpr_m <= '1;
      kpr_s <= '1;
    end else begin
      kpr_m <= kpr;
      kpr_s <= kpr_m;
    end
  end

  // Scan-rate divider: free-running 0..SCAN_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Next-state logic; every transition is gated by tick.
  always_comb begin
    state_n      = state;
    col_n        = col;
    stab_n       = stab_cnt;
    cap_n        = cap;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (all_ones) begin
            col_n = col_inc;
          end else begin
            cap_n = kpr_s;
            if (DEBOUNCE_CNT == 1) begin
              state_n = ST_HELD;
              stab_n  = '0;
              accept  = 1'b1;
            end else begin
              state_n = ST_DEBOUNCE;
              stab_n  = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (kpr_s == cap) begin
            if (stab_cnt + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              state_n = ST_HELD;
              stab_n  = '0;
              accept  = 1'b1;
            end else begin
              stab_n = stab_cnt + 4'd1;
            end
          end else begin
            state_n = ST_SCAN;
            stab_n  = '0;
          end
        end
        ST_HELD: begin
          // Only a full release matters here; row changes are ignored.
          if (all_ones) begin
            if (DEBOUNCE_CNT == 1) begin
              state_n      = ST_SCAN;
              stab_n       = '0;
              col_n        = col_inc;
              release_done = 1'b1;
            end else begin
              state_n = ST_RELEASE;
              stab_n  = 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (all_ones) begin
            if (stab_cnt + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              state_n      = ST_SCAN;
              stab_n       = '0;
              col_n        = col_inc;
              release_done = 1'b1;
            end else begin
              stab_n = stab_cnt + 4'd1;
            end
          end else begin
            state_n = ST_HELD;
            stab_n  = '0;
          end
        end
        default: begin
          state_n = ST_SCAN;
          stab_n  = '0;
        end
      endcase
    end
  end

  // Key code: lowest pressed row wins; multi_key flags more than one low row.
  always_comb begin
    row_sel  = 0;
    zero_cnt = 0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!cap_n[r]) begin
        row_sel  = r;
        zero_cnt = zero_cnt + 1;
      end
    end
    code_n  = CODE_W'(row_sel * NUM_COLS + int'(col));
    multi_n = (zero_cnt > 1);
  end

  // One-cold column pattern for the column that will be active next cycle.
  always_comb begin
    kpc_n = '1;
    for (int i = 0; i < NUM_COLS; i++) begin
      kpc_n[i] = (i != (NUM_COLS - 1 - int'(col_n)));
    end
  end

  // FSM state, scan column and debounce bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_SCAN;
      col      <= '0;
      stab_cnt <= '0;
      cap      <= '1;
      kpc      <= KPC_COL0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      stab_cnt <= stab_n;
      cap      <= cap_n;
      kpc      <= kpc_n;
    end
  end

  // Registered key reporting outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_code  <= '0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code  <= code_n;
        multi_key <= multi_n;
        key_down  <= 1'b1;
      end else if (release_done) begin
        key_down  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter NUM_COLS, default 4, column drive count; legal 2..8.
REQ-002 Parameter NUM_ROWS, default 4, row sense count; legal 2..8.
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles per scan tick; legal >= 2.
REQ-004 Parameter DEBOUNCE_CNT, default 4, consecutive matching ticks to accept press/release; legal 1..15.
REQ-005 Derived CODE_W = $clog2(NUM_ROWS*NUM_COLS).
REQ-006 Ports, in order:
- clk  input  1  sole clock, rising edge
- reset  input  1  one clock; reset is synchronous and active-high
- kpr  input  NUM_ROWS  row sense, active-low, asynchronous to clk
- kpc  output  NUM_COLS  column drive, one-cold
- key_code  output  CODE_W  row*NUM_COLS + col of accepted key
- key_valid  output  1  one-cycle pulse on accepted press
- key_down  output  1  high while accepted key is held
- multi_key  output  1  >1 row low at acceptance

Function
REQ-007 kpr SHALL pass through a 2-flop synchronizer (reset value all ones); all decisions SHALL use the synchronized value (kpr_s).
REQ-008 Divider SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be high for the one cycle in which the count equals SCAN_DIV-1.
REQ-009 Column index col SHALL drive kpc bit NUM_COLS-1-col low, all other bits high (col 0 -> 4'b0111 at default width).
REQ-010 FSM states: SCAN, DEBOUNCE, HELD, RELEASE; all transitions SHALL occur only on tick cycles.
REQ-011 SCAN, tick, kpr_s all ones: col SHALL advance by 1, wrapping NUM_COLS-1 -> 0.
REQ-012 SCAN, tick, kpr_s not all ones: capture kpr_s, stab_cnt=1, go DEBOUNCE; col SHALL hold.
REQ-013 DEBOUNCE, tick, kpr_s equals capture: stab_cnt+1; when the count reaches DEBOUNCE_CNT, go HELD (DEBOUNCE_CNT=1: go HELD on the entry tick).
REQ-014 DEBOUNCE, tick, kpr_s differs from capture: go SCAN, stab_cnt=0, col unchanged, no output change.
REQ-015 On entry to HELD: key_valid high exactly one cycle; key_code = r*NUM_COLS + col, where r is the lowest index with capture[r]=0; multi_key = (count of zeros in capture > 1); key_down=1.
REQ-016 key_code and multi_key SHALL hold until the next acceptance or reset.
REQ-017 HELD, tick, kpr_s all ones: go RELEASE, stab_cnt=1; other kpr_s changes while HELD SHALL be ignored.
REQ-018 RELEASE, tick, kpr_s all ones: stab_cnt+1; at DEBOUNCE_CNT go SCAN, key_down=0, col advances by 1 (wrap).
REQ-019 RELEASE, tick, kpr_s not all ones: return to HELD, stab_cnt=0, no new key_valid.
REQ-020 kpc SHALL be registered; col SHALL be frozen in DEBOUNCE, HELD and RELEASE.
REQ-021 Press-to-key_valid latency SHALL be at most 2 + (DEBOUNCE_CNT+1)*SCAN_DIV clk cycles.

Reset
REQ-022 While reset is high at a clk edge: state SCAN, col 0, kpc = column-0 pattern, divider 0, stab_cnt 0, synchronizer all ones, key_code 0, key_valid 0, key_down 0, multi_key 0.
REQ-023 Reset in any state, including mid-DEBOUNCE or HELD, SHALL take effect on the next edge with no key_valid emitted.

Verification (NUM_COLS=NUM_ROWS=4, SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-024 Reset 2 cycles, kpr=4'hF -> kpc=0111, all outputs 0; kpc then steps 1011, 1101, 1110, 0111, one step per 4 clks.
REQ-025 kpr=4'b1101 held while kpc=1101 -> key_valid one pulse after 3 matching ticks, key_code=6, multi_key=0, key_down=1, kpc held at 1101.
REQ-026 kpr=4'b1101 for 1 tick then 4'hF -> no key_valid, FSM returns to SCAN, scanning resumes from the same column.
REQ-027 kpr=4'b1001 at col 0 -> key_code=4, multi_key=1.
REQ-028 From HELD, kpr=4'hF for 3 ticks -> key_down=0, kpc advances to the next column; a 1-tick release glitch -> key_down stays 1, no second key_valid.
REQ-029 Reset asserted 1 cycle while HELD -> next cycle kpc=0111, key_down=0, key_code=0.
